vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameters (name, default, meaning): H_ACTIVE 1280 visible pixels; H_FP 64 front porch; H_SYNC 136 sync width; H_BP 200 back porch; V_ACTIVE 800 visible lines; V_FP 1; V_SYNC 3; V_BP 27; HS_POL 0 active hsync level; VS_POL 1 active vsync level.
REQ-002 Derived constants: H_TOTAL = 1680 and V_TOTAL = 831.
REQ-003 clk  input  1  pixel clock, 83.46 MHz; one clock, all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 hsync, vsync  input  1 each  sync inputs, synchronous to clk.
REQ-006 pix_r, pix_g, pix_b  input  4 each  pixel colour.
REQ-007 rx_x  output  11  recovered column; rx_y  output  10  recovered row.
REQ-008 rx_r, rx_g, rx_b  output  4 each  registered colour.
REQ-009 rx_valid  output  1  active pixel present on rx_* this cycle.
REQ-010 locked  output  1  timing matches parameters.
REQ-011 line_len  output  12  clocks between the last two hsync leading edges.
REQ-012 frame_lines  output  11  hsync edges between the last two vsync leading edges.
REQ-013 err  output  1  one-cycle pulse on loss of lock.

Function
REQ-014 The block SHALL register all inputs once (stage 1); leading edges are detected as stage-1 active AND previous stage-1 inactive.
REQ-015 h_cnt (12 bit): the first pixel with hsync active SHALL have index 0; each later clock increments by 1.
REQ-016 h_cnt SHALL saturate at 4095 and not wrap.
REQ-017 v_cnt (11 bit) SHALL increment on each hsync leading edge and be set to 0 on a vsync leading edge; when both edges coincide, 0 wins.
REQ-018 A pixel is active when h_cnt is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and v_cnt is in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
REQ-019 For an active pixel: rx_x = h_cnt-(H_SYNC+H_BP) and rx_y = v_cnt-(V_SYNC+V_BP).
REQ-020 Latency: a pixel present on the inputs in cycle n SHALL appear on rx_x, rx_y, rx_r/g/b and rx_valid in cycle n+2.
REQ-021 rx_valid SHALL be 1 only for an active pixel while locked=1; rx_r/g/b SHALL be 0 when rx_valid=0.
REQ-022 On each hsync leading edge, line_len SHALL be loaded with (clocks since the previous edge), saturated at 4095.
REQ-023 On each vsync leading edge, frame_lines SHALL be loaded with (hsync edges since the previous vsync edge), saturated at 2047.
REQ-024 The lock FSM SHALL have states UNLOCKED, H_OK, V_ARM and LOCKED.
REQ-025 UNLOCKED -> H_OK after two consecutive measured line_len == H_TOTAL.
REQ-026 H_OK -> V_ARM on the next vsync leading edge.
REQ-027 V_ARM -> LOCKED on the next vsync leading edge if frame_lines == V_TOTAL; otherwise V_ARM -> UNLOCKED.
REQ-028 In H_OK, V_ARM or LOCKED, any measured line_len != H_TOTAL, or h_cnt reaching 4095, SHALL cause -> UNLOCKED and a one-cycle err pulse.
REQ-029 In LOCKED, a vsync edge with frame_lines != V_TOTAL SHALL cause -> UNLOCKED and a one-cycle err pulse.
REQ-030 In UNLOCKED, a mismatch SHALL only restart the two-line count; err stays 0.
REQ-031 locked SHALL be registered and equal 1 exactly while the state is LOCKED.
REQ-032 The LOCKED -> UNLOCKED transition and the err pulse SHALL occur in the same cycle; rx_valid SHALL be 0 from that cycle.

Reset
REQ-033 While rst=0, all outputs, counters and input registers SHALL be 0 and the state SHALL be UNLOCKED, independent of clk.
REQ-034 After rst rises, the first hsync leading edge SHALL NOT update line_len; measurement starts at the second edge.

Verification
REQ-035 rst=0 with random toggling inputs -> all outputs 0 and locked=0 on every cycle.
REQ-036 Three nominal 1280x800 frames -> line_len=1680, frame_lines=831; locked rises 2 cycles after the third vsync leading edge.
REQ-037 After lock, input pixel F/0/A at the first active position -> rx_x=0, rx_y=0, rx_valid=1, rx_r/g/b=F/0/A exactly 2 cycles later.
REQ-038 After lock, pixel (1279,799) -> rx_valid=1 with rx_x=1279, rx_y=799; rx_valid=0 on the next cycle.
REQ-039 Inject one 1679-clock line while locked -> err=1 for one cycle and locked=0 at the edge; locked=1 again after the normal re-lock sequence.
REQ-040 Hold hsync inactive for 5000 clocks while locked -> err pulse and locked=0 when h_cnt hits 4095; mid-frame rst=0 -> outputs 0 immediately and re-lock per REQ-036.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers pixel coordinates from hsync/vsync, measures line and
// frame timing, and only passes the pixel stream once the timing has locked.
module vga_sync_decoder #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 64,
  parameter int   H_SYNC   = 136,
  parameter int   H_BP     = 200,
  parameter int   V_ACTIVE = 800,
  parameter int   V_FP     = 1,
  parameter int   V_SYNC   = 3,
  parameter int   V_BP     = 27,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  pix_r,
  input  logic [3:0]  pix_g,
  input  logic [3:0]  pix_b,
  output logic [10:0] rx_x,
  output logic [9:0]  rx_y,
  output logic [3:0]  rx_r,
  output logic [3:0]  rx_g,
  output logic [3:0]  rx_b,
  output logic        rx_valid,
  output logic        locked,
  output logic [11:0] line_len,
  output logic [10:0] frame_lines,
  output logic        err
);
  localparam logic [11:0] H_TOTAL = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [10:0] V_TOTAL = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [11:0] H_START = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_END   = 12'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [10:0] V_START = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_END   = 11'(V_SYNC + V_BP + V_ACTIVE - 1);

  typedef enum logic [1:0] {UNLOCKED, H_OK, V_ARM, LOCKED} state_t;

  logic        hs_s1, vs_s1, hs_s1_prev, vs_s1_prev;
  logic [3:0]  r_s1, g_s1, b_s1;
  logic        h_edge, v_edge;
  logic [11:0] h_cnt_q, h_inc, h_cnt;
  logic [10:0] v_cnt_q, v_meas, v_cnt;
  logic        seen_h;
  logic        line_evt, line_match, frame_match, h_sat;
  state_t      state, state_nx;
  logic        good, good_nx, fault;
  logic        active, valid_nx, err_nx;
  logic [11:0] x_off;
  logic [10:0] y_off;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_s1      <= 1'b0;
      vs_s1      <= 1'b0;
      hs_s1_prev <= 1'b0;
      vs_s1_prev <= 1'b0;
      r_s1       <= '0;
      g_s1       <= '0;
      b_s1       <= '0;
    end else begin
      hs_s1      <= hsync;
      vs_s1      <= vsync;
      hs_s1_prev <= hs_s1;
      vs_s1_prev <= vs_s1;
      r_s1       <= pix_r;
      g_s1       <= pix_g;
      b_s1       <= pix_b;
    end
  end

  assign h_edge = (hs_s1 == HS_POL) && (hs_s1_prev != HS_POL);
  assign v_edge = (vs_s1 == VS_POL) && (vs_s1_prev != VS_POL);

  // h_inc doubles as the measured line length: the pixel before an edge holds L-1.
  always_comb begin
    h_inc  = (h_cnt_q == 12'hFFF) ? 12'hFFF : h_cnt_q + 12'd1;
    h_cnt  = h_edge ? 12'd0 : h_inc;
    v_meas = (v_cnt_q == 11'h7FF || !h_edge) ? v_cnt_q : v_cnt_q + 11'd1;
    v_cnt  = v_edge ? 11'd0 : v_meas;
  end

  assign line_evt    = h_edge && seen_h;
  assign line_match  = (h_inc == H_TOTAL);
  assign frame_match = (v_meas == V_TOTAL);
  assign h_sat       = (h_cnt == 12'hFFF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      seen_h      <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
    end else begin
      h_cnt_q <= h_cnt;
      v_cnt_q <= v_cnt;
      if (h_edge) seen_h <= 1'b1;
      if (line_evt) line_len <= h_inc;
      if (v_edge) frame_lines <= v_meas;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= UNLOCKED;
      good  <= 1'b0;
    end else begin
      state <= state_nx;
      good  <= good_nx;
    end
  end

  always_comb begin
    state_nx = state;
    good_nx  = good;
    fault    = 1'b0;
    case (state)
      UNLOCKED: begin
        if (line_evt) begin
          if (!line_match) begin
            good_nx = 1'b0;
          end else if (good) begin
            state_nx = H_OK;
            good_nx  = 1'b0;
          end else begin
            good_nx = 1'b1;
          end
        end
      end
      H_OK: begin
        if ((line_evt && !line_match) || h_sat) fault = 1'b1;
        else if (v_edge) state_nx = V_ARM;
      end
      V_ARM: begin
        if ((line_evt && !line_match) || h_sat) fault = 1'b1;
        else if (v_edge) state_nx = frame_match ? LOCKED : UNLOCKED;
      end
      LOCKED: begin
        if ((line_evt && !line_match) || h_sat || (v_edge && !frame_match)) fault = 1'b1;
      end
      default: state_nx = UNLOCKED;
    endcase
    if (fault) state_nx = UNLOCKED;
  end

  always_comb begin
    active   = (h_cnt >= H_START) && (h_cnt <= H_END) && (v_cnt >= V_START) && (v_cnt <= V_END);
    valid_nx = active && (state_nx == LOCKED);
    err_nx   = fault;
    x_off    = h_cnt - H_START;
    y_off    = v_cnt - V_START;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked   <= 1'b0;
      err      <= 1'b0;
      rx_valid <= 1'b0;
      rx_x     <= '0;
      rx_y     <= '0;
      rx_r     <= '0;
      rx_g     <= '0;
      rx_b     <= '0;
    end else begin
      locked   <= (state_nx == LOCKED);
      err      <= err_nx;
      rx_valid <= valid_nx;
      if (valid_nx) begin
        rx_x <= x_off[10:0];
        rx_y <= y_off[9:0];
        rx_r <= r_s1;
        rx_g <= g_s1;
        rx_b <= b_s1;
      end else begin
        rx_x <= '0;
        rx_y <= '0;
        rx_r <= '0;
        rx_g <= '0;
        rx_b <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a reduced 16x8 raster (32 clocks/line, 15 lines/frame)
// so that full lock sequences fit in a short run; the 12-bit h_cnt saturation is unchanged.
module tb_vga_sync_decoder;
  localparam int HT = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync = 1'b1, vsync = 1'b0;
  logic [3:0]  pix_r = '0, pix_g = '0, pix_b = '0;
  logic [10:0] rx_x;
  logic [9:0]  rx_y;
  logic [3:0]  rx_r, rx_g, rx_b;
  logic        rx_valid, locked, err;
  logic [11:0] line_len;
  logic [10:0] frame_lines;

  vga_sync_decoder #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(3), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .rx_x(rx_x), .rx_y(rx_y), .rx_r(rx_r), .rx_g(rx_g), .rx_b(rx_b),
    .rx_valid(rx_valid), .locked(locked), .line_len(line_len),
    .frame_lines(frame_lines), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         x;
    int         y;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_valid = 0;
  int   n_err = 0;
  int   err_cyc = -1;
  int   rise_cyc = -1;
  int   fall_cyc = -1;
  logic locked_d = 1'b0;
  int   last_drive_cyc = 0;
  int   line_edge_cyc = 0;
  int   edge_cyc[15];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic longint outs();
    return longint'({rx_x, rx_y, rx_r, rx_g, rx_b, rx_valid, locked, line_len, frame_lines, err});
  endfunction

  // Pixel scoreboard monitor plus lock/err event recorder.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc + 2 < cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_pixel x=%0d y=%0d in_cycle=%0d now=%0d", e.x, e.y, e.cyc, cyc);
    end
    if (rx_valid) begin
      n_valid++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL stray_valid x=%0d y=%0d cycle=%0d actual=1 required=0", rx_x, rx_y, cyc);
      end else begin
        e = sb.pop_front();
        if (e.cyc + 2 != cyc || int'(rx_x) != e.x || int'(rx_y) != e.y ||
            rx_r !== e.r || rx_g !== e.g || rx_b !== e.b) begin
          errors++;
          $display("FAIL pixel actual cyc=%0d x=%0d y=%0d rgb=%h%h%h required cyc=%0d x=%0d y=%0d rgb=%h%h%h",
                   cyc, rx_x, rx_y, rx_r, rx_g, rx_b, e.cyc + 2, e.x, e.y, e.r, e.g, e.b);
        end
      end
    end else begin
      checks++;
      if ({rx_x, rx_y, rx_r, rx_g, rx_b} !== '0) begin
        errors++;
        $display("FAIL blank_pixel cycle=%0d actual x=%0d y=%0d rgb=%h%h%h required 0",
                 cyc, rx_x, rx_y, rx_r, rx_g, rx_b);
      end
    end
    if (err) begin
      n_err++;
      err_cyc = cyc;
    end
    if (locked && !locked_d) rise_cyc = cyc;
    if (!locked && locked_d) fall_cyc = cyc;
    locked_d = locked;
  end

  task automatic drive(input logic hs, input logic vs, input logic [3:0] r, input logic [3:0] g,
                       input logic [3:0] b, input bit push, input int x, input int y);
    exp_t e;
    @(posedge clk);
    #1;
    hsync = hs;
    vsync = vs;
    pix_r = r;
    pix_g = g;
    pix_b = b;
    last_drive_cyc = cyc;
    if (push) begin
      e.cyc = cyc; e.x = x; e.y = y; e.r = r; e.g = g; e.b = b;
      sb.push_back(e);
    end
  endtask

  // Line v: hsync low for h 0..5, active pixels at h 12..27 on lines 6..13, vsync high on lines 0..2.
  task automatic drive_line(input int v, input int len, input bit lk);
    for (int h = 0; h < len; h++) begin
      bit         act;
      int         x, y;
      logic [3:0] r, g, b;
      act = (h >= 12 && h <= 27 && v >= 6 && v <= 13);
      x = h - 12;
      y = v - 6;
      if (act) begin
        r = 4'(15 - x);
        g = 4'(y);
        b = 4'(x + y + 10);
      end else begin
        r = 4'($urandom);
        g = 4'($urandom);
        b = 4'($urandom);
      end
      drive((h < 6) ? 1'b0 : 1'b1, (v < 3) ? 1'b1 : 1'b0, r, g, b, lk && act, x, y);
      if (h == 0) line_edge_cyc = last_drive_cyc;
    end
  endtask

  task automatic drive_frame(input int v0, input int v1, input int lk_lo, input int lk_hi,
                             input int short_v);
    for (int v = v0; v <= v1; v++) begin
      drive_line(v, (v == short_v) ? HT - 1 : HT, (v >= lk_lo) && (v <= lk_hi));
      edge_cyc[v] = line_edge_cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_edge;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      hsync = 1'($urandom); vsync = 1'($urandom);
      pix_r = 4'($urandom); pix_g = 4'($urandom); pix_b = 4'($urandom);
      @(negedge clk);
      check("reset_outputs", outs(), 0);
    end
    @(posedge clk);
    #1;
    hsync = 1'b1; vsync = 1'b0;
    rst = 1'b1;
    idle(40);

    // Initial lock: first edge not measured, lock two cycles after third vsync edge.
    drive_frame(0, 0, 1, 0, -1);
    check("first_edge_no_measure", line_len, 0);
    drive_frame(1, 14, 1, 0, -1);
    drive_frame(0, 14, 1, 0, -1);
    check("locked_before_f3", locked, 0);
    drive_frame(0, 14, 0, 14, -1);
    check("lock_rise_f3", rise_cyc, edge_cyc[0] + 2);
    check("line_len_nominal", line_len, 32);
    check("frame_lines_nominal", frame_lines, 15);
    drive_frame(0, 14, 0, 14, -1);
    check("locked_f4", locked, 1);
    check("no_err_f4", n_err, 0);

    // Short line 9 in F5: error at the line-10 edge, then re-lock in F7.
    drive_frame(0, 14, 0, 9, 9);
    check("short_line_err_count", n_err, 1);
    check("short_line_err_cycle", err_cyc, edge_cyc[10] + 2);
    check("short_line_unlock_cycle", fall_cyc, edge_cyc[10] + 2);
    check("unlocked_after_short", locked, 0);
    drive_frame(0, 14, 1, 0, -1);
    check("not_locked_v_arm", locked, 0);
    drive_frame(0, 14, 0, 14, -1);
    check("relock_rise", rise_cyc, edge_cyc[0] + 2);
    check("relocked", locked, 1);

    // Hsync stall: err once h_cnt saturates.
    drive_frame(0, 7, 0, 14, -1);
    drive_line(8, 6 + 5000, 1'b1);
    stall_edge = line_edge_cyc;
    check("stall_err_count", n_err, 2);
    check("stall_err_cycle", err_cyc, stall_edge + 4097);
    check("stall_unlock_cycle", fall_cyc, stall_edge + 4097);
    drive_frame(0, 0, 1, 0, -1);
    check("line_len_saturated", line_len, 4095);
    drive_frame(1, 14, 1, 0, -1);
    drive_frame(0, 14, 1, 0, -1);
    drive_frame(0, 7, 0, 14, -1);
    check("stall_relock_rise", rise_cyc, edge_cyc[0] + 2);
    check("locked_before_reset", locked, 1);

    // Mid-frame asynchronous reset.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_reset_immediate", outs(), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", outs(), 0);
    end
    @(posedge clk);
    #1;
    hsync = 1'b1; vsync = 1'b0;
    rst = 1'b1;
    idle(10);
    drive_frame(0, 0, 1, 0, -1);
    check("post_reset_first_edge", line_len, 0);
    drive_frame(1, 14, 1, 0, -1);
    drive_frame(0, 14, 1, 0, -1);
    check("post_reset_not_locked", locked, 0);
    drive_frame(0, 14, 0, 14, -1);
    check("post_reset_lock_rise", rise_cyc, edge_cyc[0] + 2);
    check("post_reset_line_len", line_len, 32);
    check("post_reset_frame_lines", frame_lines, 15);

    idle(4);
    @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    check("valid_pixel_total", n_valid, 656);
    check("err_total", n_err, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
